mtr_drv: RTL

Motor drive stage directly downstream of balance control. It converts the signed 12-bit `lft_spd` and `rght_spd` commands into complementary, dead-time-protected PWM pairs for the two H-bridges. It also monitors the bridges' over-current flags and latches a shutdown that forces every gate output low.

---
 rtl/mtr_drv.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mtr_drv.sv
// Motor drive stage: clipped signed speed commands become dead-time-protected complementary
// PWM pairs for two H-bridges, with blanked over-current detection and a latched shutdown.
module mtr_drv #(
    parameter int DATA_W     = 12,
    parameter int NONOVERLAP = 32,
    parameter int BLANK      = 128,
    parameter int OVR_LIMIT  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] lft_spd,
    input  logic signed [DATA_W-1:0] rght_spd,
    input  logic                     OVR_I_lft,
    input  logic                     OVR_I_rght,
    output logic                     PWM1_lft,
    output logic                     PWM2_lft,
    output logic                     PWM1_rght,
    output logic                     PWM2_rght,
    output logic                     OVR_I_shtdwn
);

    typedef enum logic [1:0] {IDLE_LO, DEAD, HIGH, LOW} state_t;

    localparam logic [10:0]              CNT_MAX  = 11'h7FF;
    localparam logic [10:0]              DUTY_MID = 11'd1024;
    localparam logic [5:0]               DT_LOAD  = 6'(NONOVERLAP);
    localparam int                       BLK_W    = $clog2(BLANK + 1);
    localparam logic [BLK_W-1:0]         BLK_DONE = BLK_W'(BLANK);
    localparam logic signed [DATA_W-1:0] SPD_MAX  = DATA_W'(1023);
    localparam logic signed [DATA_W-1:0] SPD_MIN  = DATA_W'(-1024);
    localparam logic signed [DATA_W-1:0] SPD_OFS  = DATA_W'(1024);

    function automatic logic [10:0] spd_to_duty(input logic signed [DATA_W-1:0] spd);
        logic signed [DATA_W-1:0] lim;
        if (spd > SPD_MAX)
            lim = SPD_MAX;
        else if (spd < SPD_MIN)
            lim = SPD_MIN;
        else
            lim = spd;
        return 11'(lim + SPD_OFS);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic [10:0]       cnt;
    logic [10:0]       duty_lft;
    logic [10:0]       duty_rght;
    logic [1:0][10:0]  duty_v;
    logic [3:0]        ovr_cnt;
    logic [3:0]        ovr_cnt_nxt;
    logic              prd_end;
    logic              shtdwn_nxt;
    logic [1:0]        seen;
    logic [1:0]        qual;
    logic [1:0]        ovr_in;
    logic [1:0]        pwm1;
    logic [1:0]        pwm2;

    assign prd_end = (cnt == CNT_MAX);
    assign duty_v  = {duty_rght, duty_lft};
    assign ovr_in  = {OVR_I_rght, OVR_I_lft};

    // p0: period counter and duty capture at period end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            duty_lft  <= DUTY_MID;
            duty_rght <= DUTY_MID;
        end else begin
            cnt <= cnt + 11'd1;
            if (prd_end) begin
                duty_lft  <= spd_to_duty(lft_spd);
                duty_rght <= spd_to_duty(rght_spd);
            end
        end
    end

    // A qualified event on the period-end clock still counts for the ending period.
    always_comb begin
        ovr_cnt_nxt = ovr_cnt;
        if (prd_end)
            ovr_cnt_nxt = (|(seen | qual)) ? sat_inc(ovr_cnt) : 4'd0;
        shtdwn_nxt = OVR_I_shtdwn | (prd_end && (ovr_cnt_nxt >= 4'(OVR_LIMIT)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_cnt      <= '0;
            OVR_I_shtdwn <= 1'b0;
        end else begin
            ovr_cnt      <= ovr_cnt_nxt;
            OVR_I_shtdwn <= shtdwn_nxt;
        end
    end

    for (genvar s = 0; s < 2; s++) begin : g_side
        state_t           state;
        state_t           state_nxt;
        logic [5:0]       dt_cnt;
        logic [5:0]       dt_cnt_nxt;
        logic             sig_p0;
        logic             sig_p1;
        logic             sig_chg;
        logic             pwm1_nxt;
        logic             pwm2_nxt;
        logic             pwm1_q;
        logic             pwm2_q;
        logic             seen_q;
        logic [BLK_W-1:0] blk_cnt;

        assign sig_p0  = (cnt < duty_v[s]);
        assign sig_chg = sig_p0 ^ sig_p1;

        always_comb begin
            state_nxt  = state;
            dt_cnt_nxt = dt_cnt;
            if (sig_chg) begin
                state_nxt  = DEAD;
                dt_cnt_nxt = DT_LOAD;
            end else begin
                case (state)
                    IDLE_LO, DEAD: begin
                        if (dt_cnt <= 6'd1)
                            state_nxt = sig_p0 ? HIGH : LOW;
                        else
                            dt_cnt_nxt = dt_cnt - 6'd1;
                    end
                    default: ;
                endcase
            end
            if (shtdwn_nxt) begin
                state_nxt  = IDLE_LO;
                dt_cnt_nxt = DT_LOAD;
            end
            pwm1_nxt = (state_nxt == HIGH);
            pwm2_nxt = (state_nxt == LOW);
        end

        // p1: FSM state, gate outputs, blanking and over-current capture
        always_ff @(posedge clk) begin
            if (rst) begin
                state   <= IDLE_LO;
                dt_cnt  <= DT_LOAD;
                sig_p1  <= 1'b0;
                pwm1_q  <= 1'b0;
                pwm2_q  <= 1'b0;
                seen_q  <= 1'b0;
                blk_cnt <= '0;
            end else begin
                state  <= state_nxt;
                dt_cnt <= dt_cnt_nxt;
                sig_p1 <= sig_p0;
                pwm1_q <= pwm1_nxt;
                pwm2_q <= pwm2_nxt;
                seen_q <= prd_end ? 1'b0 : (seen_q | qual[s]);
                if ((pwm1_nxt & ~pwm1_q) | (pwm2_nxt & ~pwm2_q))
                    blk_cnt <= '0;
                else if (blk_cnt != BLK_DONE)
                    blk_cnt <= blk_cnt + BLK_W'(1);
            end
        end

        assign qual[s] = ovr_in[s] & (pwm1_q | pwm2_q) & (blk_cnt == BLK_DONE);
        assign seen[s] = seen_q;
        assign pwm1[s] = pwm1_q;
        assign pwm2[s] = pwm2_q;
    end

    assign PWM1_lft  = pwm1[0];
    assign PWM2_lft  = pwm2[0];
    assign PWM1_rght = pwm1[1];
    assign PWM2_rght = pwm2[1];

endmodule
